pla_dc1_code_decoder: RTL and testbench

// - Streaming inverse of the dc1 BCD->7-bit code map: accepts 7-bit codewords, returns the BCD digit.
// - Valid/ready in and out, 2-entry output buffer, invalid-code flag, saturating error counter.
// - Sits on the receive side of a dc1-coded display/telemetry link.
// - Code table (in_code hex, bit i = code bit z_i): 0:77 1:60 2:3E 3:7C 4:69 5:5D 6:5B 7:64 8:7F 9:6D.

---
 rtl/pla_dc1_code_decoder.sv | 191 +++++++++++++++++++
 tb/tb_pla_dc1_code_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pla_dc1_code_decoder.sv
// Streaming dc1 7-bit codeword -> BCD digit decoder with a 2-entry output buffer and a saturating error counter.
// Optional single-bit correction is enabled by defining PLA_DC1_SINGLE_BIT_CORRECT_EN.
module pla_dc1_code_decoder #(
  parameter int         CNT_W     = 8,
  parameter logic [3:0] ERR_DIGIT = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_digit,
  output logic             out_err,
  output logic             out_corr,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_cnt_clr
);

`ifdef PLA_DC1_SINGLE_BIT_CORRECT_EN
  localparam int ENTRY_W = 6;
  localparam int ERR_BIT = 1;
`else
  localparam int ENTRY_W = 5;
  localparam int ERR_BIT = 0;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_r, state_next_s;
  logic [ENTRY_W-1:0]   head_r, tail_r, head_next_s, tail_next_s;
  logic [ENTRY_W-1:0]   new_entry_s;
  logic                 push_s, pop_s;

  function automatic logic [6:0] dc1_code(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'h77;
      4'd1:    code = 7'h60;
      4'd2:    code = 7'h3E;
      4'd3:    code = 7'h7C;
      4'd4:    code = 7'h69;
      4'd5:    code = 7'h5D;
      4'd6:    code = 7'h5B;
      4'd7:    code = 7'h64;
      4'd8:    code = 7'h7F;
      4'd9:    code = 7'h6D;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

`ifdef PLA_DC1_SINGLE_BIT_CORRECT_EN
  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 7; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction
`endif

  // Entry layout: {digit, err} or, with correction, {digit, err, corr}.
  function automatic logic [ENTRY_W-1:0] decode_code(input logic [6:0] code);
    logic [3:0] digit;
    logic       err;
`ifdef PLA_DC1_SINGLE_BIT_CORRECT_EN
    logic [3:0] near_digit;
    logic [3:0] near_hits;
`endif
    digit = ERR_DIGIT;
    err   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (code == dc1_code(4'(i))) begin
        digit = 4'(i);
        err   = 1'b0;
      end else begin
        digit = digit;
      end
    end
`ifdef PLA_DC1_SINGLE_BIT_CORRECT_EN
    near_digit = 4'd0;
    near_hits  = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (popcount7(code ^ dc1_code(4'(i))) == 3'd1) begin
        near_hits  = near_hits + 4'd1;
        near_digit = 4'(i);
      end else begin
        near_hits  = near_hits;
      end
    end
    // Only an unambiguous single-bit neighbour is corrected; ties stay errors.
    if (err && (near_hits == 4'd1)) begin
      return {near_digit, 1'b0, 1'b1};
    end else begin
      return {digit, err, 1'b0};
    end
`else
    return {digit, err};
`endif
  endfunction

  assign in_ready    = (state_r != FULL);
  assign out_valid   = (state_r != EMPTY);
  assign push_s      = in_valid & in_ready;
  assign pop_s       = out_valid & out_ready;
  assign new_entry_s = decode_code(in_code);

`ifdef PLA_DC1_SINGLE_BIT_CORRECT_EN
  assign out_digit = head_r[5:2];
  assign out_err   = head_r[1];
  assign out_corr  = head_r[0];
`else
  assign out_digit = head_r[4:1];
  assign out_err   = head_r[0];
  assign out_corr  = 1'b0;
`endif

  // Occupancy state machine and buffer shifting.
  always_comb begin
    state_next_s = state_r;
    head_next_s  = head_r;
    tail_next_s  = tail_r;
    case (state_r)
      EMPTY: begin
        if (push_s) begin
          head_next_s  = new_entry_s;
          state_next_s = ONE;
        end else begin
          state_next_s = EMPTY;
        end
      end
      ONE: begin
        if (push_s && pop_s) begin
          head_next_s = new_entry_s;
        end else if (push_s) begin
          tail_next_s  = new_entry_s;
          state_next_s = FULL;
        end else if (pop_s) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = ONE;
        end
      end
      FULL: begin
        if (pop_s) begin
          head_next_s  = tail_r;
          state_next_s = ONE;
        end else begin
          state_next_s = FULL;
        end
      end
      default: begin
        state_next_s = EMPTY;
      end
    endcase
  end

  // State and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      head_r  <= {ENTRY_W{1'b0}};
      tail_r  <= {ENTRY_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      head_r  <= head_next_s;
      tail_r  <= tail_next_s;
    end
  end

  // Saturating count of accepted undecodable codes; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= {CNT_W{1'b0}};
    end else if (err_cnt_clr) begin
      err_cnt <= {CNT_W{1'b0}};
    end else if (push_s && new_entry_s[ERR_BIT] && !(&err_cnt)) begin
      err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt <= err_cnt;
    end
  end

endmodule

// File: tb/tb_pla_dc1_code_decoder.sv
// Self-checking bench for pla_dc1_code_decoder: directed steps plus a randomized stream against a queue model.
module tb_pla_dc1_code_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, out_err, out_corr, err_cnt_clr;
  logic [6:0] in_code;
  logic [3:0] out_digit;
  logic [7:0] err_cnt;

  logic       in_valid2, in_ready2, out_valid2, out_ready2, out_err2, out_corr2, err_cnt_clr2;
  logic [6:0] in_code2;
  logic [3:0] out_digit2;
  logic [1:0] err_cnt2;

  int         tests = 0;
  int         fails = 0;
  logic [5:0] q[$];
  int         cnt = 0;

  always #5 clk = ~clk;

  pla_dc1_code_decoder #(.CNT_W(8), .ERR_DIGIT(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit), .out_err(out_err),
    .out_corr(out_corr), .err_cnt(err_cnt), .err_cnt_clr(err_cnt_clr)
  );

  pla_dc1_code_decoder #(.CNT_W(2), .ERR_DIGIT(4'hF)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_code(in_code2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_digit(out_digit2), .out_err(out_err2),
    .out_corr(out_corr2), .err_cnt(err_cnt2), .err_cnt_clr(err_cnt_clr2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode: {digit, err, corr} from the code table.
  function automatic logic [5:0] ref_decode(input logic [6:0] c);
    int tbl[10] = '{'h77, 'h60, 'h3E, 'h7C, 'h69, 'h5D, 'h5B, 'h64, 'h7F, 'h6D};
    int near = 0;
    int nd = 0;
    for (int i = 0; i < 10; i++) if (int'(c) == tbl[i]) return {4'(i), 2'b00};
`ifdef PLA_DC1_SINGLE_BIT_CORRECT_EN
    for (int i = 0; i < 10; i++) begin
      if ($countones(c ^ 7'(tbl[i])) == 1) begin
        near++;
        nd = i;
      end
    end
    if (near == 1) return {4'(nd), 2'b01};
`endif
    return {4'hF, 2'b10};
  endfunction

  // One clock of the main DUT: drive at negedge, check against model, update model at posedge.
  task automatic step(input logic v, input logic [6:0] c, input logic ordy, input logic clr, output logic acc);
    logic       pop;
    logic [5:0] e;
    e = 6'd0;
    @(negedge clk);
    in_valid = v; in_code = c; out_ready = ordy; err_cnt_clr = clr;
    #1;
    check("in_ready", in_ready, q.size() < 2);
    check("out_valid", out_valid, q.size() != 0);
    check("err_cnt", err_cnt, cnt);
    if (q.size() != 0) check("head", {out_digit, out_err, out_corr}, q[0]);
    acc = v && (q.size() < 2);
    pop = ordy && (q.size() != 0);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) begin
      e = ref_decode(c);
      q.push_back(e);
    end
    if (clr) cnt = 0;
    else if (acc && e[1] && cnt < 255) cnt++;
  endtask

  task automatic send(input logic [6:0] c, input logic ordy);
    logic acc;
    for (int k = 0; k < 100; k++) begin
      step(1'b1, c, ordy, 1'b0, acc);
      if (acc) return;
    end
    check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) step(1'b0, 7'h00, 1'b1, 1'b0, acc);
  endtask

  initial begin
    logic       acc;
    logic [6:0] stream [10];
    logic [6:0] code;
    int         base;
    stream = '{7'h77, 7'h60, 7'h3E, 7'h7C, 7'h69, 7'h5D, 7'h5B, 7'h64, 7'h7F, 7'h6D};

    rst_n = 1'b0; in_valid = 1'b0; in_code = 7'h00; out_ready = 1'b0; err_cnt_clr = 1'b0;
    in_valid2 = 1'b0; in_code2 = 7'h00; out_ready2 = 1'b1; err_cnt_clr2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_digit", out_digit, 4'h0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_out_corr", out_corr, 1'b0);
    check("rst_err_cnt", err_cnt, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream of every table code.
    foreach (stream[i]) send(stream[i], 1'b1);
    idle(3);

    // Backpressure: two buffer, third waits, then drain.
    send(7'h77, 1'b0);
    send(7'h60, 1'b0);
    step(1'b1, 7'h3E, 1'b0, 1'b0, acc);
    check("full_no_accept", acc, 1'b0);
    step(1'b1, 7'h3E, 1'b0, 1'b0, acc);
    check("hold_digit", out_digit, 4'h0);
    send(7'h3E, 1'b1);
    idle(3);

    // Invalid codes.
    base = cnt;
    send(7'h00, 1'b1);
    send(7'h6F, 1'b1);
    idle(2);
    check("err_cnt_two", err_cnt, 8'(base + 2));

    // Single-bit neighbour of digit 1.
    send(7'h20, 1'b1);
    idle(2);

    // Mid-stream reset with two entries buffered.
    send(7'h00, 1'b0);
    send(7'h77, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_err_cnt", err_cnt, 8'd0);
    q.delete();
    cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);

    // Saturation and clear priority on the narrow counter.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid2 = 1'b1; in_code2 = 7'h00;
    end
    @(negedge clk);
    in_valid2 = 1'b0;
    #1;
    check("sat_err_cnt", err_cnt2, 2'd3);
    @(negedge clk);
    in_valid2 = 1'b1; err_cnt_clr2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0; err_cnt_clr2 = 1'b0;
    #1;
    check("clr_wins", err_cnt2, 2'd0);

    // Randomized stream with random backpressure and occasional clears.
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 9) < 7) code = stream[$urandom_range(0, 9)];
      else code = 7'($urandom);
      if ($urandom_range(0, 3) == 0) step(1'b0, 7'h00, 1'($urandom), 1'b0, acc);
      acc = 1'b0;
      for (int k = 0; k < 100 && !acc; k++)
        step(1'b1, code, 1'($urandom), ($urandom_range(0, 49) == 0), acc);
      if (!acc) check("rand_timeout", 32'd0, 32'd1);
    end
    idle(4);
    check("final_empty", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
